iobuf_seq: RTL and testbench



---
 rtl/iobuf_pkg.sv | 25 ++
 rtl/iobuf_seq_if.sv | 49 ++++
 rtl/iobuf_seq.sv | 118 +++++++++++
 tb/tb_iobuf_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iobuf_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : iobuf_pkg
//  Purpose   : Shared status-field encodings and sequencer state encodings
//              for the I/O buffer address sequencer.
//  Revision  : 1.0  initial release
// ============================================================================
package iobuf_pkg;

  // Status field returned by ABuf alongside each DBuf address
  localparam logic [1:0] ST_NOP   = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_STORE = 2'b10;
  localparam logic [1:0] ST_HALT  = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage : iobuf_pkg
`default_nettype wire

// File: rtl/iobuf_seq_if.sv
`default_nettype none
// ============================================================================
//  Interface : iobuf_seq_if
//  Purpose   : Control/handshake bundle between the CGRA run controller,
//              the ABuf/DBuf I/O buffer and the address sequencer.
//  Revision  : 1.0  initial release
// ============================================================================
interface iobuf_seq_if #(
  parameter int AWIDTH = 16
);

  logic              Start;
  logic [AWIDTH-1:0] End_Addr;
  logic              Stall;
  logic [1:0]        DBuf_Status;
  logic [AWIDTH-1:0] ABuf_Addr;
  logic              DBuf_Wea;
  logic              Rd_Valid;
  logic              Busy;
  logic              Done;

  // Sequencer side
  modport master (
    input  Start,
    input  End_Addr,
    input  Stall,
    input  DBuf_Status,
    output ABuf_Addr,
    output DBuf_Wea,
    output Rd_Valid,
    output Busy,
    output Done
  );

  // Controller / buffer side
  modport slave (
    output Start,
    output End_Addr,
    output Stall,
    output DBuf_Status,
    input  ABuf_Addr,
    input  DBuf_Wea,
    input  Rd_Valid,
    input  Busy,
    input  Done
  );

endinterface : iobuf_seq_if
`default_nettype wire

// File: rtl/iobuf_seq.sv
`default_nettype none
// ============================================================================
//  Module    : iobuf_seq
//  Purpose   : Walks ABuf from entry 0 to End_Addr, decodes the returned
//              status per entry into DBuf write enables and load-valid
//              flags, and handles stall / early-halt / completion.
//  Revision  : 1.0  initial release
// ============================================================================
module iobuf_seq
  import iobuf_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
) (
  input  wire logic   Clk,
  input  wire logic   Rst,
  iobuf_seq_if.master io
);

  // DWIDTH exists only to keep parameter lists aligned with the I/O buffer;
  // reject nonsensical values at elaboration.
  if (DWIDTH < 1) begin : g_dwidth_check
    $error("iobuf_seq: DWIDTH must be positive");
  end

  localparam logic [AWIDTH-1:0] ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            next_state;
  logic [AWIDTH-1:0] addr;
  logic [AWIDTH-1:0] addr_next;
  logic [AWIDTH-1:0] end_addr;
  logic [AWIDTH-1:0] end_addr_next;
  logic              issue_v;     // an ABuf entry is issued this cycle
  logic              v1;          // entry issued last cycle; status valid now
  logic              v1_next;
  logic              halt;        // HALT status seen on a valid entry
  logic              rd_valid;
  logic              busy;
  logic              done;

  assign halt    = v1 & (io.DBuf_Status == ST_HALT);
  // A HALT squashes whatever is issued alongside it
  assign v1_next = issue_v & ~halt;

  // Next-state, address counter and issue decision
  always_comb begin
    next_state    = state;
    addr_next     = addr;
    end_addr_next = end_addr;
    issue_v       = 1'b0;
    case (state)
      S_IDLE: begin
        if (io.Start) begin
          end_addr_next = io.End_Addr;
          addr_next     = '0;
          next_state    = S_RUN;
        end
      end
      S_RUN: begin
        issue_v = ~io.Stall;
        if (halt) begin
          // Early halt beats stall; address freezes on the squashed entry
          next_state = S_DRAIN;
        end else if (issue_v) begin
          // Compare before incrementing so the last entry never wraps
          if (addr == end_addr) begin
            next_state = S_DRAIN;
          end else begin
            addr_next = addr + ADDR_ONE;
          end
        end
      end
      S_DRAIN: begin
        // Wait for both pipe stages to empty; stall has no effect here
        if (!v1 && !rd_valid) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State, address and registered status outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      end_addr <= '0;
      v1       <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= next_state;
      addr     <= addr_next;
      end_addr <= end_addr_next;
      v1       <= v1_next;
      rd_valid <= v1 & (io.DBuf_Status == ST_LOAD);
      busy     <= (next_state == S_RUN) || (next_state == S_DRAIN);
      done     <= (next_state == S_DONE);
    end
  end

  // Write enable is combinational so it lines up with DBuf_Addr from ABuf
  assign io.DBuf_Wea  = v1 & (io.DBuf_Status == ST_STORE);
  assign io.ABuf_Addr = addr;
  assign io.Rd_Valid  = rd_valid;
  assign io.Busy      = busy;
  assign io.Done      = done;

endmodule : iobuf_seq
`default_nettype wire

// File: tb/tb_iobuf_seq.sv
`default_nettype none
// ============================================================================
//  Module    : tb_iobuf_seq
//  Purpose   : Self-checking bench for iobuf_seq with a registered ABuf
//              status ROM model.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_iobuf_seq;

  localparam int AW = 8;

  typedef struct {
    logic          start;
    logic [AW-1:0] end_a;
    logic          stall;
    logic [AW-1:0] addr;
    logic          wea;
    logic          rd;
    logic          busy;
    logic          done;
  } vec_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  iobuf_seq_if #(.AWIDTH(AW)) bus ();

  iobuf_seq #(.AWIDTH(AW), .DWIDTH(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .io  (bus.master)
  );

  always #5 Clk = ~Clk;

  // ABuf status ROM: status comes back one cycle after the address
  logic [1:0] rom [256];
  always @(posedge Clk) bus.DBuf_Status <= rom[bus.ABuf_Addr];

  int n_checks = 0;
  int n_fail   = 0;

  // run statistics
  int wea_cnt, rd_cnt, done_cnt, busy_cnt, max_addr, done_at, addr_dec, addr_first;

  vec_t vt [20];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 2'b00;
  endtask

  // Start a run at the current negedge, observe ncyc cycles at negedges.
  // busy_start_at : observation index after which a spurious Start (End=1) is driven
  // start_on_done : drive a spurious Start (End=5) right after Done is seen
  // stall_at      : observation index after which Stall is driven for one cycle
  task automatic run(input logic [AW-1:0] e, input int ncyc, input int busy_start_at,
                     input logic start_on_done, input int stall_at);
    int prev_addr;
    int prev_busy;
    bus.Start    = 1'b1;
    bus.End_Addr = e;
    bus.Stall    = 1'b0;
    wea_cnt = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0;
    max_addr = 0; done_at = -1; addr_dec = 0; addr_first = -1;
    prev_addr = 0; prev_busy = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge Clk);
      bus.Start    = 1'b0;
      bus.End_Addr = e;
      bus.Stall    = 1'b0;
      if (c == 0) addr_first = int'(bus.ABuf_Addr);
      if (bus.DBuf_Wea) wea_cnt++;
      if (bus.Rd_Valid) rd_cnt++;
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (int'(bus.ABuf_Addr) > max_addr) max_addr = int'(bus.ABuf_Addr);
      if (bus.Busy && prev_busy != 0 && int'(bus.ABuf_Addr) < prev_addr) addr_dec++;
      prev_addr = int'(bus.ABuf_Addr);
      prev_busy = int'(bus.Busy);
      if (c == busy_start_at) begin
        bus.Start    = 1'b1;
        bus.End_Addr = 8'd1;
      end
      if (start_on_done && bus.Done) begin
        bus.Start    = 1'b1;
        bus.End_Addr = 8'd5;
      end
      if (c == stall_at) bus.Stall = 1'b1;
    end
    bus.Start = 1'b0;
    bus.Stall = 1'b0;
  endtask

  initial begin
    int found;
    bus.Start    = 1'b0;
    bus.End_Addr = '0;
    bus.Stall    = 1'b0;
    rom_clear();

    // Table: start, end, stall | addr, wea, rd, busy, done (observed after the edge)
    // Plain run End=3, status {01,10,00,01}
    vt[0]  = '{1'b1, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 8'd3, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 8'd3, 1'b0, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    // Same run, Stall for two cycles while addr 2 is presented
    vt[9]  = '{1'b1, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 8'd3, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 8'd3, 1'b0, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[12] = '{1'b0, 8'd3, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[13] = '{1'b0, 8'd3, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[15] = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[16] = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[17] = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[18] = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[19] = '{1'b0, 8'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #1 Rst = 1'b1;
    #1;
    chk("reset_addr", int'(bus.ABuf_Addr), 0);
    chk("reset_wea",  int'(bus.DBuf_Wea), 0);
    chk("reset_rd",   int'(bus.Rd_Valid), 0);
    chk("reset_busy", int'(bus.Busy), 0);
    chk("reset_done", int'(bus.Done), 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    // Table-driven basic and stall runs
    rom[0] = 2'b01; rom[1] = 2'b10; rom[2] = 2'b00; rom[3] = 2'b01;
    for (int i = 0; i < 20; i++) begin
      bus.Start    = vt[i].start;
      bus.End_Addr = vt[i].end_a;
      bus.Stall    = vt[i].stall;
      @(negedge Clk);
      chk($sformatf("vec%0d_addr", i), int'(bus.ABuf_Addr), int'(vt[i].addr));
      chk($sformatf("vec%0d_wea", i),  int'(bus.DBuf_Wea),  int'(vt[i].wea));
      chk($sformatf("vec%0d_rd", i),   int'(bus.Rd_Valid),  int'(vt[i].rd));
      chk($sformatf("vec%0d_busy", i), int'(bus.Busy),      int'(vt[i].busy));
      chk($sformatf("vec%0d_done", i), int'(bus.Done),      int'(vt[i].done));
    end
    bus.Start = 1'b0;
    bus.Stall = 1'b0;

    // HALT at entry 2 of End=7, entry 3 is a STORE
    rom_clear();
    rom[1] = 2'b01; rom[2] = 2'b11;
    for (int i = 3; i < 8; i++) rom[i] = 2'b10;
    run(8'd7, 12, -1, 1'b0, -1);
    chk("halt_wea_cnt", wea_cnt, 0);
    chk("halt_rd_cnt", rd_cnt, 1);
    chk("halt_max_addr", max_addr, 3);
    chk("halt_done_cnt", done_cnt, 1);
    chk("halt_done_lat_ok", int'(done_at >= 5 && done_at <= 6), 1);

    // Same, with Stall coinciding with the HALT status
    run(8'd7, 12, -1, 1'b0, 3);
    chk("halt_stall_wea_cnt", wea_cnt, 0);
    chk("halt_stall_max_addr", max_addr, 3);
    chk("halt_stall_done_at", done_at, 5);

    // End_Addr = 0 with a STORE at entry 0
    rom_clear();
    rom[0] = 2'b10;
    run(8'd0, 8, -1, 1'b0, -1);
    chk("end0_wea_cnt", wea_cnt, 1);
    chk("end0_done_cnt", done_cnt, 1);
    chk("end0_busy_cnt", busy_cnt, 3);
    chk("end0_max_addr", max_addr, 0);

    // Start while Busy and in the DONE cycle must be ignored
    rom_clear();
    rom[0] = 2'b01; rom[1] = 2'b10; rom[2] = 2'b00; rom[3] = 2'b01;
    run(8'd3, 20, 2, 1'b1, -1);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_max_addr", max_addr, 3);
    chk("ign_busy_cnt", busy_cnt, 7);
    chk("ign_wea_cnt", wea_cnt, 1);
    chk("ign_rd_cnt", rd_cnt, 2);

    // Full address range: last entry issued, no wrap
    rom_clear();
    rom[0] = 2'b10; rom[255] = 2'b10;
    run(8'd255, 270, -1, 1'b0, -1);
    chk("full_wea_cnt", wea_cnt, 2);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_max_addr", max_addr, 255);
    chk("full_addr_dec", addr_dec, 0);
    chk("full_busy_cnt", busy_cnt, 258);

    // Asynchronous reset in the middle of a run
    rom_clear();
    for (int i = 0; i < 8; i++) rom[i] = 2'b10;
    bus.Start    = 1'b1;
    bus.End_Addr = 8'd7;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
      if (bus.ABuf_Addr == 8'd5) found = 1;
    end
    chk("rst_reached_addr5", found, 1);
    #2 Rst = 1'b1;
    #1;
    chk("rst_async_addr", int'(bus.ABuf_Addr), 0);
    chk("rst_async_wea",  int'(bus.DBuf_Wea), 0);
    chk("rst_async_rd",   int'(bus.Rd_Valid), 0);
    chk("rst_async_busy", int'(bus.Busy), 0);
    chk("rst_async_done", int'(bus.Done), 0);
    @(negedge Clk);
    Rst = 1'b0;
    wea_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      if (bus.DBuf_Wea) wea_cnt++;
      if (bus.Busy) busy_cnt++;
    end
    chk("rst_after_wea", wea_cnt, 0);
    chk("rst_after_busy", busy_cnt, 0);
    run(8'd1, 8, -1, 1'b0, -1);
    chk("rst_restart_addr0", addr_first, 0);
    chk("rst_restart_wea_cnt", wea_cnt, 2);
    chk("rst_restart_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_iobuf_seq
`default_nettype wire
